// File: rtl/sram_loader_pkg.sv
// Shared defaults and the loader FSM state encoding for the SRAM bank loader.
package sram_loader_pkg;

   localparam int DEF_WIDTH = 16;   // bits per word per channel
   localparam int DEF_DEPTH = 784;  // words per bank (one 28x28 image)
   localparam int DEF_N_CH  = 10;   // parallel banks

   // Loader session state; the encoding is visible on the debug port.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } state_t;

endpackage

// File: rtl/sram_bank.sv
// One single-port SRAM bank: synchronous write, registered read.
// The read register can be cleared so the top can return zero on a
// rejected read without touching the array.
module sram_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 784,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             re,
   input  logic             clr,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Array write; contents are deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= wdata;
   end

   // Read register: load on an accepted read, zero on a rejected one, else hold.
   always_ff @(posedge clk) begin
      if (reset)     r_rdata <= '0;
      else if (re)   r_rdata <= r_mem[addr];
      else if (clr)  r_rdata <= '0;
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/sram_bank_loader.sv
// Multi-channel SRAM loader: streams N_CH-wide beats into N_CH banks at an
// auto-incrementing address, then serves guarded registered reads.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready
// and start is low; in_ready is registered and only high in LOAD, and the
// producer must hold in_data stable while in_valid is high and unaccepted.
module sram_bank_loader
   import sram_loader_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int N_CH  = DEF_N_CH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic                  load_done,
   output logic [AW:0]           wr_count,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic                  rd_valid,
   output logic                  rd_err,
   output logic [N_CH*WIDTH-1:0] rd_data,
   output logic [1:0]            dbg_state
);

   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

   state_t           r_state;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_wr_count;
   logic             r_in_ready;
   logic             r_load_done;
   logic             r_rd_valid;
   logic             r_rd_err;

   logic             w_rd_ok;
   logic             w_we;
   logic             w_re;
   logic             w_clr;
   logic [AW-1:0]    w_bank_addr;

   // Read guard: only a fully loaded bank set answers in-range addresses.
   assign w_rd_ok     = (r_state == ST_FULL) && ({1'b0, rd_addr} < DEPTH_W);
   // start discards a beat offered in the same cycle.
   assign w_we        = (r_state == ST_LOAD) && in_valid && !start && !reset;
   assign w_re        = rd_en && w_rd_ok && !reset;
   assign w_clr       = rd_en && !w_rd_ok;
   // Writes only in LOAD and reads only in FULL, so one address port suffices.
   assign w_bank_addr = (r_state == ST_LOAD) ? r_wr_ptr : rd_addr;

   for (genvar c = 0; c < N_CH; c++) begin : g_bank
      sram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank (
         .clk   (clk),
         .reset (reset),
         .we    (w_we),
         .re    (w_re),
         .clr   (w_clr),
         .addr  (w_bank_addr),
         .wdata (in_data[c*WIDTH +: WIDTH]),
         .rdata (rd_data[c*WIDTH +: WIDTH])
      );
   end

   // Session FSM with write pointer, beat counter and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_wr_count  <= '0;
         r_in_ready  <= 1'b0;
         r_load_done <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_err    <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
         r_rd_err   <= rd_en && !w_rd_ok;
         if (start) begin
            r_state     <= ST_LOAD;
            r_wr_ptr    <= '0;
            r_wr_count  <= '0;
            r_in_ready  <= 1'b1;
            r_load_done <= 1'b0;
         end else begin
            case (r_state)
               ST_LOAD: begin
                  if (in_valid) begin
                     r_wr_count <= r_wr_count + (AW+1)'(1);
                     if (r_wr_ptr == LAST_A) begin
                        r_state     <= ST_FULL;
                        r_in_ready  <= 1'b0;
                        r_load_done <= 1'b1;
                     end else begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                     end
                  end
               end
               ST_FULL: begin
                  r_in_ready  <= 1'b0;
                  r_load_done <= 1'b1;
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_in_ready <= 1'b0;
               end
            endcase
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign load_done = r_load_done;
   assign wr_count  = r_wr_count;
   assign rd_valid  = r_rd_valid;
   assign rd_err    = r_rd_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_bank_loader.sv
// Bench for sram_bank_loader: randomized loads and reads against a
// session-level model (beat count, loaded flag, memory image).
module tb_sram_bank_loader;
   import sram_loader_pkg::*;

   localparam int W  = 16;
   localparam int D  = 784;
   localparam int NC = 10;
   localparam int AW = 10;
   localparam int DW = W * NC;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset, start, in_valid, rd_en;
   logic [DW-1:0] in_data;
   logic [AW-1:0] rd_addr;
   logic          in_ready, load_done, rd_valid, rd_err;
   logic [AW:0]   wr_count;
   logic [DW-1:0] rd_data;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   sram_bank_loader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .load_done (load_done),
      .wr_count  (wr_count),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_valid  (rd_valid),
      .rd_err    (rd_err),
      .rd_data   (rd_data),
      .dbg_state (dbg_state)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit            m_init    = 0;
   bit            m_active  = 0;   // a session has been started since reset
   bit            m_loaded  = 0;   // DEPTH beats taken in this session
   int            m_count   = 0;
   bit            m_rd_pend = 0;
   bit            m_rst_seen = 0;
   logic          m_rd_err  = 1'b0;
   logic [DW-1:0] m_rd_data = '0;
   logic [DW-1:0] m_mem [D];
   logic [DW:0]   exp_q [$];       // {err, data} read responses in flight

   always @(posedge clk) begin
      m_init = 1;
      if (reset) begin
         m_active = 0; m_loaded = 0; m_count = 0; m_rd_pend = 0;
         m_rst_seen = 1;
         exp_q.delete();
      end else begin
         m_rd_pend = rd_en;
         if (rd_en) begin
            if (m_loaded && int'(rd_addr) < D) exp_q.push_back({1'b0, m_mem[rd_addr]});
            else                              exp_q.push_back({1'b1, {DW{1'b0}}});
         end
         if (start) begin
            m_active = 1; m_loaded = 0; m_count = 0;
         end else if (m_active && !m_loaded && in_valid) begin
            m_mem[m_count] = in_data;
            m_count++;
            if (m_count == D) m_loaded = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_init) begin
         if (m_rst_seen) begin
            m_rd_data  = '0;
            m_rd_err   = 1'b0;
            m_rst_seen = 0;
         end
         if (m_rd_pend) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rd_queue: got empty expected one entry at %0t", $time);
            end else begin
               {m_rd_err, m_rd_data} = exp_q.pop_front();
            end
         end else begin
            m_rd_err = 1'b0;
         end
         chk("in_ready",  DW'(in_ready),  DW'(m_active && !m_loaded));
         chk("load_done", DW'(load_done), DW'(m_loaded));
         chk("wr_count",  DW'(wr_count),  DW'(m_count));
         chk("rd_valid",  DW'(rd_valid),  DW'(m_rd_pend));
         chk("rd_err",    DW'(rd_err),    DW'(m_rd_err));
         chk("rd_data",   rd_data,        m_rd_data);
         chk("state",     DW'(dbg_state), DW'(m_loaded ? 2 : (m_active ? 1 : 0)));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input bit with_valid);
      start    = 1'b1;
      in_valid = with_valid;
      for (int c = 0; c < NC; c++) in_data[c*W +: W] = W'($urandom);
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   // Feed beats until n have been taken or the bank set is full.
   task automatic load(input bit pat0, input int duty, input int n);
      int cyc = 0;
      while (m_count < n && !m_loaded) begin
         in_valid = ($urandom_range(99) < duty);
         for (int c = 0; c < NC; c++) begin
            if (pat0) in_data[c*W +: W] = {4'(c), 12'(m_count)};
            else      in_data[c*W +: W] = W'($urandom);
         end
         tick();
         cyc++;
         if (cyc > 20000) begin
            checks++; failures++;
            $display("FAIL load_timeout: got %0d beats expected %0d", m_count, n);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic rd(input int a);
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      tick();
      rd_en   = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
      rd_addr = '0; in_data = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("rst_wr_count",  DW'(wr_count),  DW'(0));
      chk("rst_load_done", DW'(load_done), DW'(0));
      chk("rst_in_ready",  DW'(in_ready),  DW'(0));
      chk("rst_rd_data",   rd_data,        DW'(0));

      rd(5);
      chk("idle_rd_err", DW'(rd_err), DW'(1));

      // partial load, read during LOAD is rejected
      do_start(0);
      load(0, 100, 100);
      chk("partial_count", DW'(wr_count), DW'(100));
      rd(5);
      chk("load_rd_err",  DW'(rd_err),  DW'(1));
      chk("load_rd_data", rd_data,      DW'(0));

      // restart with a concurrent beat: the beat is dropped
      do_start(1);
      chk("restart_count", DW'(wr_count), DW'(0));

      // full pattern load at full rate
      load(1, 100, D);
      chk("full_done",  DW'(load_done), DW'(1));
      chk("full_count", DW'(wr_count),  DW'(784));
      chk("full_ready", DW'(in_ready),  DW'(0));

      rd(0);
      chk("rd0_ch5", DW'(rd_data[5*W +: W]), DW'(16'h5000));
      rd(93);
      chk("rd93_ch3",   DW'(rd_data[3*W +: W]), DW'(16'h305D));
      chk("rd93_valid", DW'(rd_valid),          DW'(1));
      rd(783);
      chk("rd783_ch0", DW'(rd_data[0 +: W]),   DW'(16'h030F));
      chk("rd783_ch9", DW'(rd_data[9*W +: W]), DW'(16'h930F));
      chk("rd783_err", DW'(rd_err),            DW'(0));
      rd(784);
      chk("rd784_err",  DW'(rd_err), DW'(1));
      chk("rd784_data", rd_data,     DW'(0));
      rd(1023);
      chk("rd1023_err", DW'(rd_err), DW'(1));

      // in_valid while FULL is ignored
      in_valid = 1'b1;
      repeat (5) tick();
      in_valid = 1'b0;
      chk("full_hold_count", DW'(wr_count), DW'(784));

      // fresh random load with gaps, full back-to-back readback
      do_start(0);
      load(0, 50, D);
      for (int a = 0; a < D; a++) begin
         rd_en   = 1'b1;
         rd_addr = AW'(a);
         tick();
      end
      rd_en = 1'b0;
      tick();

      // reset mid-load abandons the session
      do_start(0);
      load(0, 70, 400);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("midrst_done",  DW'(load_done), DW'(0));
      chk("midrst_count", DW'(wr_count),  DW'(0));
      rd(10);
      chk("midrst_rd_err", DW'(rd_err), DW'(1));

      // new full load, then random reads including out-of-range addresses
      do_start(0);
      load(0, 50, D);
      for (int i = 0; i < 300; i++) begin
         rd_en   = ($urandom_range(3) != 0);
         rd_addr = AW'($urandom_range(1023));
         tick();
      end
      rd_en = 1'b0;
      repeat (2) tick();

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rd_queue_drain: got %0d left expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
